// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Brief    : CPU peripheral-bus bundle for spi_master (select, data, strobes).
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_if;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       bus_cyc;
    logic       bus_we;

    modport master (
        output addr,
        output data_in,
        output bus_cyc,
        output bus_we,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  bus_cyc,
        input  bus_we,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : Bus-mapped SPI master with TX/RX FIFOs, clock divider and level
//            irq. Define SPI_CS_AUTO_EN to add CTRL bit7 (automatic CS_n).
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire          clk_i,
    input  wire          rst,
    spi_master_if.slave  bus,
    output logic         irq,
    output logic         SCK,
    output logic         MOSI,
    input  wire          MISO,
    output logic         CS_n
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
`ifdef SPI_CS_AUTO_EN
    localparam logic [7:0] c_CTRL_MASK = 8'hDF;
`else
    localparam logic [7:0] c_CTRL_MASK = 8'h5F;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_bus_cyc_d;
    logic [7:0]           r_ctrl;
    logic [7:0]           r_div;
    logic                 r_ovr;
    logic                 r_busy;
    logic                 r_sck;
    logic                 r_mosi;
    logic                 r_cpha;
    logic [7:0]           r_shift;
    logic [7:0]           r_rx_sh;
    logic [7:0]           r_hp_cnt;
    logic [4:0]           r_edge_cnt;

    logic [7:0]           r_tx_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_tx_wp;
    logic [c_PTR_W-1:0]   r_tx_rp;
    logic [c_CNT_W-1:0]   r_tx_cnt;
    logic [7:0]           r_rx_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_rx_wp;
    logic [c_PTR_W-1:0]   r_rx_rp;
    logic [c_CNT_W-1:0]   r_rx_cnt;

    logic w_access, w_wr, w_rd;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_lead;
    logic [7:0] w_tx_head, w_rx_head, w_status;

    // One register operation per bus_cyc assertion, however long it is held.
    assign w_access   = bus.bus_cyc & ~r_bus_cyc_d;
    assign w_wr       = w_access & bus.bus_we;
    assign w_rd       = w_access & ~bus.bus_we;

    assign w_tx_full  = (r_tx_cnt == c_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_tx_head  = r_tx_mem[r_tx_rp];
    assign w_rx_head  = r_rx_mem[r_rx_rp];

    assign w_tx_push  = w_wr & (bus.addr == 2'd0) & ~w_tx_full;
    assign w_tx_pop   = (r_state == S_LOAD) & r_ctrl[0];
    assign w_rx_push  = (r_state == S_DONE) & ~w_rx_full;
    assign w_rx_pop   = w_rd & (bus.addr == 2'd0) & ~w_rx_empty;

    assign w_status   = {2'b00, r_ovr, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full, r_busy};

    always_comb begin
        bus.data_out = 8'h00;
        case (bus.addr)
            2'd0:    bus.data_out = w_rx_empty ? 8'h00 : w_rx_head;
            2'd1:    bus.data_out = w_status;
            2'd2:    bus.data_out = r_ctrl;
            default: bus.data_out = r_div;
        endcase
    end

    assign irq  = (r_ctrl[3] & ~w_rx_empty) | (r_ctrl[4] & w_tx_empty & ~r_busy) | r_ovr;
    assign SCK  = r_sck;
    assign MOSI = r_mosi;
`ifdef SPI_CS_AUTO_EN
    assign CS_n = r_ctrl[7] ? ~r_busy : ~r_ctrl[6];
`else
    assign CS_n = ~r_ctrl[6];
`endif

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_bus_cyc_d <= 1'b0;
            r_ctrl      <= 8'h00;
            r_div       <= 8'h00;
            r_ovr       <= 1'b0;
        end else begin
            r_bus_cyc_d <= bus.bus_cyc;
            if (w_wr && bus.addr == 2'd2) r_ctrl <= bus.data_in & c_CTRL_MASK;
            if (w_wr && bus.addr == 2'd3) r_div  <= bus.data_in;
            if (r_state == S_DONE && w_rx_full)
                r_ovr <= 1'b1;
            else if (w_wr && bus.addr == 2'd1 && bus.data_in[5])
                r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= 8'h00;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= bus.data_in;
                r_tx_wp           <= r_tx_wp + c_PTR_W'(1);
            end
            if (w_tx_pop) r_tx_rp <= r_tx_rp + c_PTR_W'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - c_CNT_W'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= 8'h00;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= r_rx_sh;
                r_rx_wp           <= r_rx_wp + c_PTR_W'(1);
            end
            if (w_rx_pop) r_rx_rp <= r_rx_rp + c_PTR_W'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - c_CNT_W'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Edge number r_edge_cnt+1 is odd (leading) when r_edge_cnt is even.
    assign w_lead = ~r_edge_cnt[0];

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cpha     <= 1'b0;
            r_shift    <= 8'h00;
            r_rx_sh    <= 8'h00;
            r_hp_cnt   <= 8'h00;
            r_edge_cnt <= 5'd0;
        end else if ((r_state == S_LOAD || r_state == S_SHIFT) && !r_ctrl[0]) begin
            // Abort: partial byte is dropped, queued TX bytes stay put.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sck   <= r_ctrl[1];
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sck <= r_ctrl[1];
                    if (r_ctrl[0] && !w_tx_empty) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_shift    <= w_tx_head;
                    r_mosi     <= w_tx_head[7];
                    r_cpha     <= r_ctrl[2];
                    r_hp_cnt   <= r_div;
                    r_edge_cnt <= 5'd0;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_hp_cnt != 8'd0) begin
                        r_hp_cnt <= r_hp_cnt - 8'd1;
                    end else begin
                        r_hp_cnt   <= r_div;
                        r_sck      <= ~r_sck;
                        r_edge_cnt <= r_edge_cnt + 5'd1;
                        if (w_lead ^ r_cpha) begin
                            r_rx_sh <= {r_rx_sh[6:0], MISO};
                        end else if (r_edge_cnt != 5'd15) begin
                            // CPHA=1 drives the current MSB on each leading edge.
                            r_mosi  <= r_cpha ? r_shift[7] : r_shift[6];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                        if (r_edge_cnt == 5'd15) r_state <= S_DONE;
                    end
                end
                default: begin
                    if (r_ctrl[0] && !w_tx_empty) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
